// File: rtl/my_quant_pkg.sv
// Shared definitions for the quantize/drain stage: FSM encoding, packing
// geometry and saturation limits for both the unsigned and signed builds.
package my_quant_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int ELEMS_PER_WORD = 4;
  localparam int BLK_WIDTH_DEF  = 8;
  localparam int GROUPS         = BLK_WIDTH_DEF * BLK_WIDTH_DEF / ELEMS_PER_WORD;

  localparam int U_MAX = 255;
  localparam int S_MAX = 127;
  localparam int S_MIN = -128;

endpackage

// File: rtl/my_quant_unit.sv
// Combinational requantizer: rounding right shift plus saturation to 8 bits.
// Build option QUANT_SIGNED_EN selects signed [-128,127] output instead of
// the default ReLU + unsigned [0,255] path.
module my_quant_unit
  import my_quant_pkg::*;
(
  input  logic [31:0] x,
  input  logic [4:0]  shift,
  output logic [7:0]  q
);

  logic [32:0] rnd;

  // Half-LSB rounding term; no rounding when the shift is zero.
  always_comb begin
    rnd = '0;
    if (shift != 5'd0) rnd = 33'd1 << (shift - 5'd1);
  end

`ifdef QUANT_SIGNED_EN
  logic signed [32:0] sum;
  logic signed [32:0] shr;

  // Signed round, arithmetic shift, clamp to int8.
  always_comb begin
    sum = $signed({x[31], x}) + $signed(rnd);
    shr = sum >>> shift;
    if (shr > 33'(S_MAX))      q = 8'h7F;
    else if (shr < 33'(S_MIN)) q = 8'h80;
    else                       q = shr[7:0];
  end
`else
  logic [32:0] sum;
  logic [32:0] shr;

  // ReLU, then unsigned round and logical shift, clamp to uint8.
  always_comb begin
    sum = {1'b0, x} + rnd;
    shr = sum >> shift;
    if (x[31])                 q = 8'h00;
    else if (shr > 33'(U_MAX)) q = 8'hFF;
    else                       q = shr[7:0];
  end
`endif

endmodule

// File: rtl/my_quant_drain.sv
// Drain stage after the PE-array matmul: reads the 32-bit results from BRAM,
// requantizes each to 8 bits, packs four per word and writes them back.
// Optional build macro: QUANT_SIGNED_EN (signed int8 output, no ReLU).
module my_quant_drain
  import my_quant_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int BRAM_WE_WIDTH   = 4,
  parameter int BLK_WIDTH       = 8,
  parameter int SRC_BASE        = 0,
  parameter int DST_BASE        = 128,
  parameter int RD_LATENCY      = 1,
  parameter int DONE_LENGTH     = 5
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  input  logic                       start,
  input  logic [4:0]                 shift,
  output logic                       done,
  output logic                       busy,
  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [BRAM_DATA_WIDTH-1:0] BRAM_RDDATA,
  output logic [BRAM_DATA_WIDTH-1:0] BRAM_WRDATA,
  output logic [BRAM_WE_WIDTH-1:0]   BRAM_WE
);

  localparam int NGRP = BLK_WIDTH * BLK_WIDTH / ELEMS_PER_WORD;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int WAW  = BRAM_ADDR_WIDTH - 2;
  localparam int SW   = $clog2(RD_LATENCY + 1);
  localparam int DW   = (DONE_LENGTH > 1) ? $clog2(DONE_LENGTH) : 1;

  logic [1:0]                 state;
  logic [GW-1:0]              g;
  logic [1:0]                 idx;
  logic [SW-1:0]              sub;
  logic [DW-1:0]              dcnt;
  logic [BRAM_DATA_WIDTH-1:0] pack;
  logic [4:0]                 shift_q;
  logic [7:0]                 q;
  logic [WAW-1:0]             word_addr;

  my_quant_unit u_quant (
    .x     (BRAM_RDDATA[31:0]),
    .shift (shift_q),
    .q     (q)
  );

  // Job sequencer: each read slot holds the address RD_LATENCY+1 cycles and
  // captures on its last cycle; one write per group of four elements.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state   <= S_IDLE;
      g       <= '0;
      idx     <= '0;
      sub     <= '0;
      dcnt    <= '0;
      pack    <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          shift_q <= shift;
          g       <= '0;
          idx     <= '0;
          sub     <= '0;
          state   <= S_READ;
        end
        S_READ: begin
          if (sub == SW'(RD_LATENCY)) begin
            pack[{idx, 3'b000} +: 8] <= q;
            sub <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= S_WRITE;
          end else begin
            sub <= sub + SW'(1);
          end
        end
        S_WRITE: begin
          if (g == GW'(NGRP - 1)) begin
            dcnt  <= '0;
            state <= S_DONE;
          end else begin
            g     <= g + GW'(1);
            state <= S_READ;
          end
        end
        default: begin
          if (dcnt == DW'(DONE_LENGTH - 1)) state <= S_IDLE;
          else dcnt <= dcnt + DW'(1);
        end
      endcase
    end
  end

  // Address and write-port decode from the current state.
  always_comb begin
    word_addr = '0;
    if (state == S_READ)  word_addr = WAW'(SRC_BASE) + WAW'({g, idx});
    if (state == S_WRITE) word_addr = WAW'(DST_BASE) + WAW'(g);
  end

  assign BRAM_ADDR   = {word_addr, 2'b00};
  assign BRAM_WE     = (state == S_WRITE) ? '1 : '0;
  assign BRAM_WRDATA = (state == S_WRITE) ? pack : '0;
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_my_quant_drain.sv
// Scoreboard bench for my_quant_drain: stimulus pushes expected BRAM writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_my_quant_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  shift;
  logic        done, busy;
  logic [31:0] BRAM_ADDR, BRAM_WRDATA, rd_q;
  logic [3:0]  BRAM_WE;
  logic [29:0] wa;

  always #5 clk = ~clk;

  my_quant_drain dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .shift(shift),
    .done(done), .busy(busy), .BRAM_ADDR(BRAM_ADDR), .BRAM_RDDATA(rd_q),
    .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE)
  );

  int pc = 0;
  int start_pc = 0;
  always @(posedge clk) pc <= pc + 1;

  // BRAM model: sources at words 0..63, destinations at 128..143, 1-cycle read.
  logic [31:0] srcm [64];
  logic [31:0] dstm [16];
  logic        fill_dst = 1'b0;
  assign wa = BRAM_ADDR[31:2];
  always @(posedge clk) begin
    rd_q <= (wa < 30'd64) ? srcm[wa[5:0]] : 32'h0;
    if (fill_dst) begin
      for (int i = 0; i < 16; i++) dstm[i] <= 32'hDEADBEEF;
    end else if (BRAM_WE == 4'hF && wa >= 30'd128 && wa < 30'd144) begin
      dstm[wa[3:0]] <= BRAM_WRDATA;
    end
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (BRAM_WE !== 4'h0) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr %h data %h, expected none", BRAM_ADDR, BRAM_WRDATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", BRAM_ADDR, e.addr);
        chk("wr_data", BRAM_WRDATA, e.data);
        chk("wr_we", {28'h0, BRAM_WE}, 32'hF);
        if (e.cyc >= 0) chk("wr_cycle", pc - start_pc, e.cyc);
      end
    end
  end

  // Done tracker: absolute cycle of the last rising edge and last high cycle.
  int d_first_pc = -1, d_last_pc = -1;
  logic done_d = 1'b0;
  always @(negedge clk) begin
    if (done && !done_d) d_first_pc <= pc;
    if (done) d_last_pc <= pc;
    done_d <= done;
  end

  function automatic logic [31:0] ramp_word(input int g);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*g); b1 = 8'(4*g+1); b2 = 8'(4*g+2); b3 = 8'(4*g+3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push(input int g, input logic [31:0] d, input int cyc);
    exp_t e;
    e.addr = 32'((128 + g) * 4); e.data = d; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic push_ramp(input int ngrp);
    for (int g = 0; g < ngrp; g++) push(g, ramp_word(g), 9 + 9*g);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 64; k++) srcm[k] = 32'(256 * k);
  endtask

  task automatic load4(input logic [31:0] a, b, c, d);
    for (int k = 0; k < 64; k++) srcm[k] = 32'h0;
    srcm[0] = a; srcm[1] = b; srcm[2] = c; srcm[3] = d;
  endtask

  task automatic push_word0(input logic [31:0] w0);
    push(0, w0, 9);
    for (int g = 1; g < 16; g++) push(g, 32'h0, 9 + 9*g);
  endtask

  // Called at a negedge: drive start for one cycle (cycle 0 of the job).
  task automatic go(input logic [4:0] sh);
    start = 1'b1; shift = sh; start_pc = pc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (pc - start_pc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
    @(negedge clk);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; shift = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_we", {28'h0, BRAM_WE}, 32'h0);
    chk("rst_wrdata", BRAM_WRDATA, 32'h0);
    chk("rst_addr", BRAM_ADDR, 32'h0);

    // Ramp 256*k, shift 8 -> byte k; full timing check.
    load_ramp();
    push_ramp(16);
    go(5'd8);
    wait_idle("ramp");
    chk("done_first", 32'(d_first_pc - start_pc), 32'd145);
    chk("done_last", 32'(d_last_pc - start_pc), 32'd149);
    chk("ramp_w0", dstm[0], 32'h03020100);
    chk("ramp_w15", dstm[15], 32'h3F3E3D3C);

    // Rounding / ReLU / saturation, shift 4.
    load4(32'd24, -32'sd100, 32'd8, 32'd5000);
`ifdef QUANT_SIGNED_EN
    push_word0(32'h7F01FA02);
`else
    push_word0(32'hFF010002);
`endif
    go(5'd4);
    wait_idle("round");

    // shift 0, no rounding term.
    load4(32'd0, 32'd1, 32'd255, 32'd256);
`ifdef QUANT_SIGNED_EN
    push_word0(32'h7F7F0100);
`else
    push_word0(32'hFFFF0100);
`endif
    go(5'd0);
    wait_idle("shift0");

    // Negative values, shift 1.
    load4(-32'sd3, -32'sd300, 32'd255, 32'd3);
`ifdef QUANT_SIGNED_EN
    push_word0(32'h027F80FF);
`else
    push_word0(32'h02800000);
`endif
    go(5'd1);
    wait_idle("neg");

    // Reset at cycle 40: groups 0..3 written, nothing after.
    fill_dst = 1'b1;
    @(negedge clk);
    fill_dst = 1'b0;
    load_ramp();
    push_ramp(4);
    go(5'd8);
    wait_cyc(40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_we", {28'h0, BRAM_WE}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    repeat (5) @(negedge clk);
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    chk("midrst_w3", dstm[3], 32'h0F0E0D0C);
    chk("midrst_w4", dstm[4], 32'hDEADBEEF);
    chk("midrst_w15", dstm[15], 32'hDEADBEEF);
    push_ramp(16);
    go(5'd8);
    wait_idle("rerun");
    chk("rerun_w15", dstm[15], 32'h3F3E3D3C);

    // start at cycles 20 and 146 (shift 0) must be ignored.
    push_ramp(16);
    go(5'd8);
    wait_cyc(20);
    start = 1'b1; shift = 5'd0;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(146);
    start = 1'b1; shift = 5'd0;
    @(negedge clk);
    start = 1'b0;
    wait_idle("busy_start");
    repeat (20) @(negedge clk);
    chk("busy_start_idle", {31'h0, busy}, 32'h0);
    chk("busy_start_sb", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_quant_drain.md
Name: my_quant_drain

Overview:
- Downstream stage of the 8x8 PE-array matmul block; runs after that block's done pulse.
- Reads the 64 signed 32-bit fixed-point results the array wrote to BRAM at word addresses 0..63.
- Applies rounding right-shift requantization with saturation (ReLU by default), packs four 8-bit values per word and writes 16 packed words back to BRAM.
- Driven by the same AXI-side start/done control registers as the PE array.

Parameters:
- BRAM_ADDR_WIDTH, 32, byte address width.
- BRAM_DATA_WIDTH, 32, BRAM word width.
- BRAM_WE_WIDTH, 4, byte-enable width.
- BLK_WIDTH, 8, matrix dimension; element count is BLK_WIDTH**2.
- SRC_BASE, 0, word address of the first result element.
- DST_BASE, 128, word address of the first packed output word.
- RD_LATENCY, 1, BRAM read latency in cycles (address to RDDATA valid), 1..3.
- DONE_LENGTH, 5, done-high duration in cycles.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous active-high reset.
- start  in  1  level/pulse; sampled only in IDLE.
- shift  in  5  right-shift amount, latched when start is accepted.
- done  out  1  high for DONE_LENGTH cycles at end of job.
- busy  out  1  high in any state other than IDLE.
- BRAM_ADDR  out  BRAM_ADDR_WIDTH  byte address = {word_addr, 2'b00}.
- BRAM_RDDATA  in  BRAM_DATA_WIDTH  read data.
- BRAM_WRDATA  out  BRAM_DATA_WIDTH  packed output word; 0 outside WRITE.
- BRAM_WE  out  BRAM_WE_WIDTH  4'hF in WRITE only, else 0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any cycle, including mid-job):
  - state=IDLE; all counters, pack register and latched shift cleared.
  - Outputs: done=0, busy=0, BRAM_WE=0, BRAM_WRDATA=0, BRAM_ADDR=0.
  - No partial write completes.
- States IDLE -> READ -> WRITE -> (READ | DONE) -> IDLE.
- IDLE:
  - On start=1: latch shift, clear group counter g (0..15), go READ next cycle.
- READ:
  - Phase counter p runs 0..4*(RD_LATENCY+1)-1.
  - Element index i = p/(RD_LATENCY+1).
  - Word address = SRC_BASE + 4g + i, held for the whole slot.
  - At p%(RD_LATENCY+1)==RD_LATENCY, capture the quantized BRAM_RDDATA into byte lane i ([8i+7:8i]) of the pack register.
  - After the last phase, go WRITE.
- WRITE (1 cycle):
  - Word address = DST_BASE + g, BRAM_WRDATA = pack register, BRAM_WE = 4'hF.
  - If g==15 go DONE, else g+1 and go READ.
- DONE:
  - done=1 for exactly DONE_LENGTH cycles, then IDLE.
- Timing:
  - Per group: 4*(RD_LATENCY+1)+1 cycles.
  - RD_LATENCY=1: start accepted at cycle 0, first WE at cycle 9, last WE at cycle 144, done cycles 145..149.
- start while busy (including DONE) is ignored; a new job needs start in IDLE.
- Quantization, per element x (signed 32):
  - ReLU: x<0 -> 0.
  - Else widen to 33 bits, add 2^(shift-1) when shift>0 (no rounding term when shift=0), then logical right shift by shift.
  - Saturate to 255; no wrap.
  - shift>=31 yields 0 for all x except rounding of values >=2^30.
- Read data is consumed only at the capture phase; RDDATA is don't-care otherwise.

Optional Feature:
- Macro QUANT_SIGNED_EN.
- Defined:
  - No ReLU.
  - Signed arithmetic shift with rounding term 2^(shift-1) added in 33-bit signed arithmetic.
  - Saturate to [-128,127]; byte stored in two's complement.
- Undefined: ReLU + unsigned [0,255] path as above.
- Timing and addressing are identical in both builds.

Decomposition:
- Package my_quant_pkg holds:
  - state encoding (S_IDLE, S_READ, S_WRITE, S_DONE, 2 bits);
  - ELEMS_PER_WORD=4, GROUPS=BLK_WIDTH**2/4;
  - the saturation limits for both builds.
- One natural sub-module, my_quant_unit: purely combinational, x[31:0] + shift[4:0] -> q[7:0], containing the ReLU/round/saturate logic and the QUANT_SIGNED_EN switch.
- The top module holds the FSM, counters, address generation and pack register.

Test Plan:
- Unsigned basic (RD_LATENCY=1): elements k=0..63 = 256*k, shift=8, start pulse.
  - DST word 0 = 32'h03020100, word 15 = 32'h3F3E3D3C.
  - First WE at cycle 9; done high cycles 145..149.
- Rounding/ReLU/saturation, shift=4: elements 0..3 = 24, -100, 8, 5000.
  - q = 2, 0, 1 (tie 8 rounds up 0.5->1), 255 -> word 0 = 32'hFF010002.
- shift=0, elements 0..3 = 0, 1, 255, 256 -> word 0 = 32'hFFFF0100 (256 saturates).
- Reset mid-job: assert S_AXI_ARESET at cycle 40 for 1 cycle.
  - Next cycle: state IDLE, BRAM_WE=0, done=0.
  - DST words 4..15 unchanged; a new start reruns fully.
- Start ignored while busy: pulse start at cycles 20 and 146 with shift=0.
  - Exactly 16 writes occur, all with the shift latched at cycle 0; no second job.
- QUANT_SIGNED_EN build, shift=1: elements 0..3 = -3, -300, 255, 3.
  - q = -1 (-3+1=-2, >>1=-1), -128, 127, 2 -> word 0 = 32'h027F80FF.
